binary_div_22_11_uni: RTL

//  Unsigned sequential radix-2 restoring divider: 2*DW-bit dividend / DW-bit divisor -> quotient + remainder.

---
 rtl/binary_div_pkg.sv | 17 +
 rtl/binary_div_step.sv | 31 +++
 rtl/binary_div_22_11_uni.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/binary_div_pkg.sv
// Shared definitions for the 2*DW / DW unsigned restoring divider.
//   DW_DEF  : default divisor/remainder width (dividend/quotient are 2*DW_DEF)
//   state_t : FSM encoding (IDLE=0, RUN=1, DONE=2)
//   DBZ_Q   : quotient reported on divide-by-zero (all ones) at the default width
package binary_div_pkg;

    localparam int DW_DEF = 11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [2*DW_DEF-1:0] DBZ_Q = '1;

endpackage

// File: rtl/binary_div_step.sv
// One combinational restoring-division step.
//   pr_in  : partial remainder entering the step (always < d)
//   n_bit  : next dividend bit, MSB first
//   d      : divisor
//   pr_out : partial remainder after optional subtract (< d)
//   qbit   : quotient bit produced by this step
module binary_div_step
    import binary_div_pkg::*;
#(
    parameter int DW = DW_DEF
) (
    input  logic [DW-1:0] pr_in,
    input  logic          n_bit,
    input  logic [DW-1:0] d,
    output logic [DW-1:0] pr_out,
    output logic          qbit
);

    // Shifted remainder needs one extra bit before the compare.
    logic [DW:0] sh;
    logic [DW:0] diff;

    always_comb begin
        sh     = {pr_in, n_bit};
        diff   = sh - {1'b0, d};
        qbit   = (sh >= {1'b0, d});
        // After a successful subtract the result is < d, so DW bits suffice.
        pr_out = qbit ? diff[DW-1:0] : sh[DW-1:0];
    end

endmodule

// File: rtl/binary_div_22_11_uni.sv
// Unsigned sequential radix-2 restoring divider, 2*DW-bit dividend by DW-bit
// divisor, one quotient bit per enabled clock edge.
//   clk, rst (sync, active-high), en (clock enable)
//   start, N, D : request and operands, accepted in IDLE/DONE
//   Q, R        : quotient / remainder, stable from done until next accept
//   busy, done  : iterating flag, one-enabled-edge completion pulse
//   dbz         : divide-by-zero flag (Q=all ones, R=0)
//   chk_err     : Q*D+R != N mismatch flag
// Optional feature: define BINARY_DIV_SELFCHECK_EN to build the Q*D+R check;
// otherwise chk_err is tied low and no multiplier exists.
module binary_div_22_11_uni
    import binary_div_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int CW = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic            start,
    input  logic [2*DW-1:0] N,
    input  logic [DW-1:0]   D,
    output logic [2*DW-1:0] Q,
    output logic [DW-1:0]   R,
    output logic            busy,
    output logic            done,
    output logic            dbz,
    output logic            chk_err
);

    state_t          state_q;
    logic [CW-1:0]   cnt_q;
    logic [2*DW-1:0] n_q;     // dividend, shifted left; MSB feeds each step
    logic [DW-1:0]   d_q;
    logic [2*DW-1:0] q_q;
    logic [DW-1:0]   pr_q;
    logic            busy_q, done_q, dbz_q;

    logic [DW-1:0]   pr_d;
    logic            qbit;
    logic [2*DW-1:0] q_d;
    logic            accept;
    logic            last_step;

    binary_div_step #(.DW(DW)) u_step (
        .pr_in  (pr_q),
        .n_bit  (n_q[2*DW-1]),
        .d      (d_q),
        .pr_out (pr_d),
        .qbit   (qbit)
    );

    assign q_d       = {q_q[2*DW-2:0], qbit};
    assign accept    = start && (state_q == S_IDLE || state_q == S_DONE);
    assign last_step = (state_q == S_RUN) && (cnt_q == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            n_q     <= '0;
            d_q     <= '0;
            q_q     <= '0;
            pr_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
        end else if (en) begin
            done_q <= 1'b0;
            unique case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        n_q   <= N;
                        d_q   <= D;
                        pr_q  <= '0;
                        cnt_q <= CW'(2*DW-1);
                        if (D == '0) begin
                            // Divide-by-zero short-circuits straight to DONE.
                            state_q <= S_DONE;
                            q_q     <= '1;
                            dbz_q   <= 1'b1;
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q <= S_RUN;
                            q_q     <= '0;
                            dbz_q   <= 1'b0;
                            busy_q  <= 1'b1;
                        end
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_RUN: begin
                    n_q  <= n_q << 1;
                    q_q  <= q_d;
                    pr_q <= pr_d;
                    if (cnt_q == '0) begin
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

`ifdef BINARY_DIV_SELFCHECK_EN
    // Original dividend is kept because n_q is consumed by the shifting.
    logic [2*DW-1:0] nlat_q;
    logic            chk_q;
    logic [3*DW-1:0] recon;

    // Reconstruct from the values about to be registered on the final step.
    assign recon = (3*DW)'(q_d) * (3*DW)'(d_q) + (3*DW)'(pr_d);

    always_ff @(posedge clk) begin
        if (rst) begin
            nlat_q <= '0;
            chk_q  <= 1'b0;
        end else if (en) begin
            if (accept) begin
                nlat_q <= N;
                chk_q  <= 1'b0;
            end else if (last_step) begin
                chk_q  <= (recon != (3*DW)'(nlat_q));
            end
        end
    end

    assign chk_err = chk_q;
`else
    assign chk_err = 1'b0;
`endif

    assign Q    = q_q;
    assign R    = pr_q;
    assign busy = busy_q;
    assign done = done_q;
    assign dbz  = dbz_q;

endmodule
